// File: rtl/tt_capture_pkg.sv
// Shared types for the truth-table capture sweeper.
// State encoding, default depth, counter width helper.
package tt_capture_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    DONE
  } state_e;

  localparam int N_IN_DFLT = 5;
  localparam int DEPTH     = 2**N_IN_DFLT;

  // Mismatch counter must hold the full table depth.
  function automatic int cnt_width(input int n_in);
    return n_in + 1;
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Settle down-counter for the capture sweeper.
// Strobes on the final cycle of each held vector.
module tt_settle_timer #(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic strobe
);

  localparam int W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign strobe = run && (cnt_q == '0);

  // Reload on a new sweep and after every sample, else count down.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = W'(SETTLE);
    end else if (run) begin
      if (cnt_q == '0) cnt_d = W'(SETTLE);
      else             cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/truth_table_capture.sv
// Sweeps every minterm of a patch circuit and builds its truth table.
// Compares against a snapshot of the golden table and reports a verdict.
module truth_table_capture
  import tt_capture_pkg::*;
#(
  parameter int N_IN   = N_IN_DFLT,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   expected,
  output logic [N_IN-1:0]      stim,
  input  logic                 resp,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   table_out,
  output logic [N_IN:0]        mismatch_cnt,
  output logic [N_IN-1:0]      first_fail,
  output logic                 first_fail_vld,
  output logic                 pass
);

  localparam int TD = 2**N_IN;
  localparam int CW = cnt_width(N_IN);

  state_e          state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [TD-1:0]   exp_q, exp_d;
  logic [TD-1:0]   tbl_q, tbl_d;
  logic [CW-1:0]   mc_q, mc_d;
  logic [N_IN-1:0] ff_q, ff_d;
  logic            ffv_q, ffv_d;
  logic            pass_q, pass_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            miss;
  logic            load;
  logic            strobe;

  assign load = (state_q == IDLE) && start;

  tt_settle_timer #(
    .SETTLE (SETTLE)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .run    (state_q == DRIVE),
    .strobe (strobe)
  );

  // Next-state and result updates for the sweep.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    exp_d   = exp_q;
    tbl_d   = tbl_q;
    mc_d    = mc_q;
    ff_d    = ff_q;
    ffv_d   = ffv_q;
    pass_d  = pass_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    miss    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DRIVE;
          exp_d   = expected;
          idx_d   = '0;
          tbl_d   = '0;
          mc_d    = '0;
          ff_d    = '0;
          ffv_d   = 1'b0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      DRIVE: begin
        if (strobe) begin
          tbl_d[idx_q] = resp;
          miss = resp != exp_q[idx_q];
          if (miss) mc_d = mc_q + 1'b1;
          if (miss && !ffv_q) begin
            ff_d  = idx_q;
            ffv_d = 1'b1;
          end
          if (&idx_q) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (mc_d == '0);
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      exp_q   <= '0;
      tbl_q   <= '0;
      mc_q    <= '0;
      ff_q    <= '0;
      ffv_q   <= 1'b0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      exp_q   <= exp_d;
      tbl_q   <= tbl_d;
      mc_q    <= mc_d;
      ff_q    <= ff_d;
      ffv_q   <= ffv_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign stim           = idx_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign table_out      = tbl_q;
  assign mismatch_cnt   = mc_q;
  assign first_fail     = ff_q;
  assign first_fail_vld = ffv_q;
  assign pass           = pass_q;

endmodule

// File: tb/tb_truth_table_capture.sv
// Bench for truth_table_capture with SETTLE = 1, 0 and 3.
// Random patch tables scored against a table-level reference model.
module tb_truth_table_capture;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [2:0]          start = '0;
  logic [2:0][31:0]    expected = '0;
  logic [2:0][4:0]     stim;
  logic [2:0]          resp;
  logic [2:0]          busy;
  logic [2:0]          done;
  logic [2:0][31:0]    tbl;
  logic [2:0][5:0]     mc;
  logic [2:0][4:0]     ff;
  logic [2:0]          ffv;
  logic [2:0]          pass;
  logic [2:0][31:0]    rt = '0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign resp[g] = rt[g][stim[g]];
    truth_table_capture #(
      .N_IN   (5),
      .SETTLE ((g == 1) ? 0 : (g == 2) ? 3 : 1)
    ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start[g]),
      .expected       (expected[g]),
      .stim           (stim[g]),
      .resp           (resp[g]),
      .busy           (busy[g]),
      .done           (done[g]),
      .table_out      (tbl[g]),
      .mismatch_cnt   (mc[g]),
      .first_fail     (ff[g]),
      .first_fail_vld (ffv[g]),
      .pass           (pass[g])
    );
  end

  function automatic int settle_of(input int g);
    return (g == 1) ? 0 : (g == 2) ? 3 : 1;
  endfunction

  // Busy length, stim hold lengths and done pulses per instance.
  int       bcnt [3];
  int       runl [3];
  int       bad  [3];
  int       dcnt [3];
  bit       pbusy[3];
  bit [4:0] pstim[3];

  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (busy[g] && !pbusy[g]) begin
        bcnt[g] = 1;
        runl[g] = 1;
        bad[g]  = (stim[g] != 5'd0) ? 1 : 0;
        dcnt[g] = 0;
      end else if (busy[g]) begin
        bcnt[g]++;
        if (stim[g] == pstim[g]) begin
          runl[g]++;
        end else begin
          if (runl[g] != settle_of(g) + 1) bad[g]++;
          if (int'(stim[g]) != int'(pstim[g]) + 1) bad[g]++;
          runl[g] = 1;
        end
      end
      if (done[g]) dcnt[g]++;
      pbusy[g] = busy[g];
      pstim[g] = stim[g];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: patch table vs golden snapshot, minterm by minterm.
  task automatic model(input logic [31:0] t, input logic [31:0] ex,
                       output int m, output int f, output bit fv,
                       output bit ps);
    m  = 0;
    f  = 0;
    fv = 0;
    for (int i = 0; i < 32; i++) begin
      if (t[i] != ex[i]) begin
        if (!fv) f = i;
        fv = 1;
        m++;
      end
    end
    ps = (m == 0);
  endtask

  task automatic sweep(input int g, input logic [31:0] t,
                       input logic [31:0] ex, input bit poke,
                       input bit chg, input bit hold);
    int s;
    bit got;
    int m, f;
    bit fv, ps;
    s = settle_of(g);
    rt[g] = t;
    @(negedge clk);
    expected[g] = ex;
    start[g] = 1'b1;
    @(negedge clk);
    if (!hold) start[g] = 1'b0;
    chk("lat_busy", 64'(busy[g]), 64'd1);
    chk("lat_stim", 64'(stim[g]), 64'd0);
    got = 0;
    for (int c = 1; c < 5000; c++) begin
      if (done[g]) begin
        got = 1;
        break;
      end
      if (poke && c == 10) start[g] = 1'b1;
      if (poke && c == 11) start[g] = 1'b0;
      if (chg && c == 20) expected[g] = ~ex;
      @(negedge clk);
    end
    if (!got) begin
      chk("done_timeout", 64'd0, 64'd1);
      return;
    end
    model(t, ex, m, f, fv, ps);
    chk("table", 64'(tbl[g]), 64'(t));
    chk("mcnt", 64'(mc[g]), 64'(m));
    chk("ffail", 64'(ff[g]), 64'(f));
    chk("ffvld", 64'(ffv[g]), 64'(fv));
    chk("pass", 64'(pass[g]), 64'(ps));
    chk("busy_low", 64'(busy[g]), 64'd0);
    chk("busy_len", 64'(bcnt[g]), 64'(32 * (s + 1)));
    chk("stim_seq", 64'(bad[g]), 64'd0);
    chk("last_hold", 64'(runl[g]), 64'(s + 1));
    if (!hold) begin
      repeat (3) @(negedge clk);
      chk("done_once", 64'(dcnt[g]), 64'd1);
      chk("idle_busy", 64'(busy[g]), 64'd0);
      chk("hold_tbl", 64'(tbl[g]), 64'(t));
      chk("hold_pass", 64'(pass[g]), 64'(ps));
    end
  endtask

  task automatic chk_zero(input int g, input string tag);
    chk({tag, "_stim"}, 64'(stim[g]), 64'd0);
    chk({tag, "_busy"}, 64'(busy[g]), 64'd0);
    chk({tag, "_done"}, 64'(done[g]), 64'd0);
    chk({tag, "_tbl"}, 64'(tbl[g]), 64'd0);
    chk({tag, "_mc"}, 64'(mc[g]), 64'd0);
    chk({tag, "_ff"}, 64'(ff[g]), 64'd0);
    chk({tag, "_ffv"}, 64'(ffv[g]), 64'd0);
    chk({tag, "_pass"}, 64'(pass[g]), 64'd0);
  endtask

  initial begin
    logic [31:0] par;
    logic [31:0] t;
    logic [31:0] mask;
    logic [4:0]  v;
    bit          got;
    int          g;

    for (int i = 0; i < 32; i++) begin
      v = 5'(i);
      par[i] = ^v;
    end

    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) chk_zero(k, "rst");
    rst = 1'b0;

    sweep(0, par, par, 0, 0, 0);
    sweep(0, ~par, par, 0, 0, 0);
    t = par;
    t[13] = ~t[13];
    sweep(0, t, par, 0, 0, 0);
    sweep(1, par, par, 0, 0, 0);
    sweep(2, ~par, par, 0, 0, 0);
    sweep(0, $urandom, $urandom, 1, 0, 0);
    sweep(2, $urandom, $urandom, 0, 1, 0);

    sweep(1, par, par, 0, 0, 1);
    @(negedge clk);
    chk("hold_idle", 64'(busy[1]), 64'd0);
    @(negedge clk);
    chk("hold_restart", 64'(busy[1]), 64'd1);
    chk("hold_stim", 64'(stim[1]), 64'd0);
    start[1] = 1'b0;
    got = 0;
    for (int c = 0; c < 500; c++) begin
      if (done[1]) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    chk("hold_done", 64'(got), 64'd1);
    chk("hold_len", 64'(bcnt[1]), 64'd32);
    chk("hold_pass2", 64'(pass[1]), 64'd1);

    t = $urandom;
    rt[0] = t;
    @(negedge clk);
    expected[0] = ~t;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    got = 0;
    for (int c = 0; c < 500; c++) begin
      if (stim[0] == 5'd7) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    chk("reach_vec7", 64'(got), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_zero(0, "midrst");
    sweep(0, par, par, 0, 0, 0);

    for (int r = 0; r < 20; r++) begin
      g = $urandom_range(0, 2);
      t = $urandom;
      mask = ($urandom_range(0, 3) == 0) ? 32'd0
           : ($urandom & $urandom & $urandom);
      sweep(g, t, t ^ mask, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
